// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// A grant lasts until its owner drops req or until MAX_HOLD cycles have
// elapsed. On either release the grant is handed to the next requester
// in rotating priority order within the same edge, so no idle cycle
// appears between owners.
module arbiter_rr4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       ck,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       expired
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Value of cnt on the last cycle a grant is allowed to last.
  localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] gnt_next;
  logic [1:0] owner_next;
  logic       expired_next;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       release_vol;
  logic       timeout;

  // Winner search: scan last+1, last+2, last+3, last; first request wins.
  // While granted, owner equals last, so the current owner naturally sits
  // at lowest priority. On a voluntary release its req is already low, so
  // it can only win again on a timeout.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_reg + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register: all arbiter state and registered outputs.
  always_ff @(posedge ck or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      gnt       <= 4'b0000;
      owner     <= 2'd0;
      last_reg  <= 2'd3;
      cnt_reg   <= 8'd0;
      expired   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt       <= gnt_next;
      owner     <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      expired   <= expired_next;
    end
  end

  // Next-state logic: grant, hold, release, handover and timeout decisions.
  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt;
    owner_next   = owner;
    last_next    = last_reg;
    cnt_next     = cnt_reg;
    expired_next = 1'b0;
    release_vol  = 1'b0;
    timeout      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << win_idx;
          owner_next = win_idx;
          last_next  = win_idx;
          cnt_next   = 8'd0;
        end
      end
      GRANT: begin
        // A dropped request takes precedence: a grant the owner gave up
        // on its own is not reported as expired.
        release_vol = !req[owner];
        timeout     = req[owner] && (cnt_reg == CNT_LAST);
        if (release_vol || timeout) begin
          expired_next = timeout;
          if (win_found) begin
            gnt_next   = 4'b0001 << win_idx;
            owner_next = win_idx;
            last_next  = win_idx;
            cnt_next   = 8'd0;
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            cnt_next   = 8'd0;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Output decode: busy follows the registered state, so it matches OR of gnt.
  always_comb begin
    busy = (state_reg == GRANT);
  end

endmodule
